// File: rtl/ocra1_seq.sv
// ocra1_seq: paces 4-channel DAC updates into ocra1_iface and issues the one-time DAC init burst.
module ocra1_seq #(
    parameter int unsigned INTERVAL_W   = 16,
    parameter int unsigned MIN_INTERVAL = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  init_req_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    input  logic [17:0]           vx_i,
    input  logic [17:0]           vy_i,
    input  logic [17:0]           vz_i,
    input  logic [17:0]           vz2_i,
    input  logic                  v_valid_i,
    output logic                  v_ready_o,
    output logic [31:0]           oc_data_o,
    output logic                  oc_valid_o,
    input  logic                  oc_busy_i,
    output logic                  init_done_o,
    output logic                  underrun_o,
    output logic                  late_o,
    output logic [15:0]           update_cnt_o
);
    localparam int unsigned SAMPLE_W = 18;
    localparam int unsigned DAC_W    = 24;
    localparam int unsigned WORD_W   = 32;
    localparam logic [DAC_W-1:0] INIT_DAC = 24'h200002;

    typedef enum logic [2:0] {
        IDLE,
        INIT_WAIT,
        INIT,
        RUN,
        WAIT_BUSY,
        SEND
    } state_t;

    state_t                    state;
    logic [INTERVAL_W-1:0]     cnt;
    logic [INTERVAL_W-1:0]     reload;
    logic [1:0]                beat;
    logic                      held;
    logic                      held_next;
    logic                      accept;
    logic                      tick;
    logic                      counting;
    logic                      send_go;
    logic [3:0][SAMPLE_W-1:0]  held_v;
    logic [3:0][SAMPLE_W-1:0]  shadow;

    function automatic logic [WORD_W-1:0] make_word(input logic [1:0] ch, input logic [DAC_W-1:0] dac);
        return {5'd0, ch, (ch == 2'd3), dac};
    endfunction

    function automatic logic [DAC_W-1:0] volt_dac(input logic [SAMPLE_W-1:0] v);
        return {4'h1, v, 2'b00};
    endfunction

    // Handshake, tick and burst-start decisions for the current cycle
    always_comb begin
        reload    = (interval_i < INTERVAL_W'(MIN_INTERVAL)) ? INTERVAL_W'(MIN_INTERVAL - 1)
                                                           : interval_i - INTERVAL_W'(1);
        tick      = (cnt == '0);
        counting  = (state == RUN) || (state == WAIT_BUSY) || (state == SEND);
        accept    = v_valid_i && v_ready_o;
        send_go   = !oc_busy_i && held &&
                    (((state == RUN) && enable_i && tick) || (state == WAIT_BUSY));
        held_next = accept ? 1'b1 : (send_go ? 1'b0 : held);
    end

    // Sequencer: holding register, interval counter, burst FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            beat         <= '0;
            held         <= 1'b0;
            held_v       <= '0;
            shadow       <= '0;
            v_ready_o    <= 1'b0;
            oc_data_o    <= '0;
            oc_valid_o   <= 1'b0;
            init_done_o  <= 1'b0;
            underrun_o   <= 1'b0;
            late_o       <= 1'b0;
            update_cnt_o <= '0;
        end else begin
            oc_valid_o <= 1'b0;
            held       <= held_next;
            v_ready_o  <= !held_next;
            if (accept) begin
                held_v <= {vz2_i, vz_i, vy_i, vx_i};
            end
            if (counting) begin
                cnt <= tick ? reload : cnt - INTERVAL_W'(1);
            end

            case (state)
                IDLE: begin
                    if (init_req_i) begin
                        state <= INIT_WAIT;
                    end else if (enable_i && init_done_o) begin
                        cnt   <= reload;
                        state <= RUN;
                    end
                end
                INIT_WAIT: begin
                    if (!oc_busy_i) begin
                        oc_valid_o <= 1'b1;
                        oc_data_o  <= make_word(2'd0, INIT_DAC);
                        beat       <= 2'd1;
                        state      <= INIT;
                    end
                end
                INIT: begin
                    oc_valid_o <= 1'b1;
                    oc_data_o  <= make_word(beat, INIT_DAC);
                    beat       <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        init_done_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (!held) begin
                            underrun_o <= 1'b1;
                        end else if (send_go) begin
                            shadow     <= held_v;
                            oc_valid_o <= 1'b1;
                            oc_data_o  <= make_word(2'd0, volt_dac(held_v[0]));
                            beat       <= 2'd1;
                            state      <= SEND;
                        end else begin
                            state <= WAIT_BUSY;
                        end
                    end
                end
                WAIT_BUSY: begin
                    if (tick) begin
                        late_o <= 1'b1;
                    end
                    if (send_go) begin
                        shadow     <= held_v;
                        oc_valid_o <= 1'b1;
                        oc_data_o  <= make_word(2'd0, volt_dac(held_v[0]));
                        beat       <= 2'd1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    oc_valid_o <= 1'b1;
                    oc_data_o  <= make_word(beat, volt_dac(shadow[beat]));
                    beat       <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        update_cnt_o <= update_cnt_o + 16'd1;
                        state        <= enable_i ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ocra1_seq.sv
// tb_ocra1_seq: scoreboard bench for ocra1_seq; every accepted sample or init request queues its words.
module tb_ocra1_seq;
    localparam int unsigned INTERVAL_W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable_i;
    logic                  init_req_i;
    logic [INTERVAL_W-1:0] interval_i;
    logic [17:0]           vx_i, vy_i, vz_i, vz2_i;
    logic                  v_valid_i;
    logic                  v_ready_o;
    logic [31:0]           oc_data_o;
    logic                  oc_valid_o;
    logic                  oc_busy_i;
    logic                  init_done_o;
    logic                  underrun_o;
    logic                  late_o;
    logic [15:0]           update_cnt_o;

    logic busy_dir;
    logic busy_rnd;
    logic rand_busy;
    assign oc_busy_i = busy_dir | (rand_busy & busy_rnd);

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int first_cyc   = -1;
    int bursts_seen = 0;
    int mon_updates = 0;
    int exp_updates = 0;
    logic [31:0] exp_q[$];

    ocra1_seq dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .init_req_i   (init_req_i),
        .interval_i   (interval_i),
        .vx_i         (vx_i),
        .vy_i         (vy_i),
        .vz_i         (vz_i),
        .vz2_i        (vz2_i),
        .v_valid_i    (v_valid_i),
        .v_ready_o    (v_ready_o),
        .oc_data_o    (oc_data_o),
        .oc_valid_o   (oc_valid_o),
        .oc_busy_i    (oc_busy_i),
        .init_done_o  (init_done_o),
        .underrun_o   (underrun_o),
        .late_o       (late_o),
        .update_cnt_o (update_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        busy_rnd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            busy_rnd = ($urandom_range(0, 5) == 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference word: channel in bits 26:25, last flag on channel 3, DAC payload below
    function automatic logic [31:0] exp_word(input int ch, input int dac);
        return 32'(ch * 33554432 + ((ch == 3) ? 16777216 : 0) + dac);
    endfunction

    // Voltage payload: prefix 0x1 above the 18-bit code, code scaled by 4
    function automatic int volt_dac(input int v);
        int m;
        m = v % 262144;
        if (m < 0) m += 262144;
        return 1048576 + m * 4;
    endfunction

    function automatic int rs();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_init_words();
        for (int ch = 0; ch < 4; ch++) exp_q.push_back(exp_word(ch, 'h200002));
    endtask

    task automatic push_sample(input int x, input int y, input int z, input int z2);
        int waited;
        waited    = 0;
        vx_i      = 18'(x);
        vy_i      = 18'(y);
        vz_i      = 18'(z);
        vz2_i     = 18'(z2);
        v_valid_i = 1'b1;
        while (!v_ready_o && waited < 1000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("sample_accept", v_ready_o, 1);
        if (v_ready_o) begin
            @(posedge clk);
            #1;
            exp_q.push_back(exp_word(0, volt_dac(x)));
            exp_q.push_back(exp_word(1, volt_dac(y)));
            exp_q.push_back(exp_word(2, volt_dac(z)));
            exp_q.push_back(exp_word(3, volt_dac(z2)));
            exp_updates++;
        end
        v_valid_i = 1'b0;
    endtask

    task automatic init_burst();
        int c0;
        c0         = cyc;
        init_req_i = 1'b1;
        push_init_words();
        @(posedge clk);
        #1;
        init_req_i = 1'b0;
        wait_cycles(8);
        check("init_done", init_done_o, 1);
        check("init_first_word_cycle", first_cyc, c0 + 2);
    endtask

    // Monitor: pops one expected word per valid beat and checks burst shape
    initial begin
        logic        prev_valid;
        logic        prev_last;
        logic        prev_busy;
        logic [31:0] exp;
        prev_valid = 1'b0;
        prev_last  = 1'b1;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid  = 1'b0;
                prev_last   = 1'b1;
                prev_busy   = 1'b0;
                mon_updates = 0;
            end else begin
                if (prev_valid && !prev_last) check("burst_contiguous", oc_valid_o, 1);
                if (oc_valid_o) begin
                    if (oc_data_o[26:25] == 2'd0) begin
                        check("busy_low_before_burst", prev_busy, 0);
                        first_cyc = cyc;
                    end
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: actual 0x%0h required no valid word at cycle %0d",
                                 oc_data_o, cyc);
                    end else begin
                        exp = exp_q.pop_front();
                        check("word", oc_data_o, exp);
                        if (exp[24]) begin
                            bursts_seen++;
                            if (exp[23:20] == 4'h1) begin
                                mon_updates++;
                                check("update_cnt_track", update_cnt_o, mon_updates % 65536);
                            end
                        end
                    end
                end
                prev_valid = oc_valid_o;
                prev_last  = oc_data_o[24];
                prev_busy  = oc_busy_i;
            end
        end
    end

    initial begin
        int c0;
        int b0;
        int t_tick;
        int ok;
        rst        = 1'b1;
        enable_i   = 1'b0;
        init_req_i = 1'b0;
        interval_i = 16'd100;
        vx_i       = '0;
        vy_i       = '0;
        vz_i       = '0;
        vz2_i      = '0;
        v_valid_i  = 1'b0;
        busy_dir   = 1'b0;
        rand_busy  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", oc_valid_o, 0);
        check("rst_ready", v_ready_o, 0);
        check("rst_init_done", init_done_o, 0);
        check("rst_update_cnt", update_cnt_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_late", late_o, 0);
        rst = 1'b0;
        wait_cycles(2);
        check("ready_after_reset", v_ready_o, 1);

        // Init burst
        init_burst();

        // First periodic update, interval 100
        interval_i = 16'd100;
        push_sample(1, 2, 3, 4);
        c0       = cyc;
        enable_i = 1'b1;
        wait_until(c0 + 106);
        check("first_update_cycle", first_cyc, c0 + 101);
        check("update_cnt_1", update_cnt_o, 1);

        // Busy held 30 cycles past the tick
        t_tick = c0 + 100;
        while (t_tick <= cyc) t_tick += 100;
        busy_dir = 1'b1;
        push_sample(-1, -2, -3, -4);
        wait_until(t_tick + 30);
        busy_dir = 1'b0;
        wait_until(t_tick + 40);
        check("busy_release_cycle", first_cyc, t_tick + 31);
        check("late_still_clear", late_o, 0);
        check("underrun_still_clear", underrun_o, 0);

        // Underrun with clamped interval
        enable_i = 1'b0;
        wait_cycles(3);
        interval_i = 16'd3;
        b0         = bursts_seen;
        c0         = cyc;
        enable_i   = 1'b1;
        wait_until(c0 + 8);
        check("underrun_before_tick", underrun_o, 0);
        wait_until(c0 + 9);
        check("underrun_at_tick", underrun_o, 1);
        check("ready_during_underrun", v_ready_o, 1);
        wait_cycles(20);
        check("no_burst_on_underrun", bursts_seen, b0);

        // Late tick while waiting on busy
        busy_dir = 1'b1;
        b0       = bursts_seen;
        push_sample(9, -9, 77, -77);
        wait_cycles(30);
        check("late_set", late_o, 1);
        check("no_burst_while_busy", bursts_seen, b0);
        busy_dir = 1'b0;
        wait_cycles(30);
        check("one_burst_after_late", bursts_seen, b0 + 1);

        // Reset in the middle of a burst
        push_sample(5, 6, 7, 8);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (oc_valid_o && oc_data_o[26:25] == 2'd1) begin
                ok = 1;
                break;
            end
        end
        check("reach_second_word", ok, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", oc_valid_o, 0);
        check("rst_mid_ready", v_ready_o, 0);
        check("rst_mid_init_done", init_done_o, 0);
        check("rst_mid_underrun", underrun_o, 0);
        check("rst_mid_late", late_o, 0);
        check("rst_mid_update_cnt", update_cnt_o, 0);
        exp_q.delete();
        exp_updates = 0;
        enable_i    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_valid", oc_valid_o, 0);
        check("rst_hold_ready", v_ready_o, 0);
        rst = 1'b0;
        wait_cycles(2);
        check("ready_after_rst2", v_ready_o, 1);
        check("init_done_cleared", init_done_o, 0);
        init_burst();

        // Disable in the middle of a burst
        interval_i = 16'd10;
        b0         = bursts_seen;
        push_sample(100, 200, 300, 400);
        enable_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (oc_valid_o && oc_data_o[26:25] == 2'd0) begin
                ok = 1;
                break;
            end
        end
        check("reach_first_word", ok, 1);
        #1;
        enable_i = 1'b0;
        wait_cycles(10);
        check("burst_completes_after_disable", bursts_seen, b0 + 1);
        check("update_cnt_after_reset", update_cnt_o, 1);
        push_sample(11, 22, 33, 44);
        wait_cycles(40);
        check("idle_after_disable", bursts_seen, b0 + 1);

        // Randomized traffic with random busy
        rand_busy = 1'b1;
        enable_i  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            interval_i = 16'($urandom_range(3, 16));
            push_sample(rs(), rs(), rs(), rs());
            wait_cycles(int'($urandom_range(0, 25)));
        end
        rand_busy = 1'b0;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_cycles(1);
        check("drain", exp_q.size(), 0);
        wait_cycles(2);
        check("final_update_cnt", update_cnt_o, exp_updates);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
